// File: rtl/share_encoder.sv
// share_encoder
//   Converts a plaintext word into a SHARES-share Boolean masking for the
//   masked datapath. Two registered stages with valid/ready flow control:
//     stage 1 latches the fresh masks and the plaintext pre-masked with mask 0.
//     stage 2 registers the final share vector; the last share is built by
//     XOR-ing the remaining masks in one at a time.
//   A plaintext word and a randomness word are always consumed together.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   in_valid/in_ready  plaintext handshake, in_data[WIDTH-1:0]
//   rnd_valid/rnd_ready randomness handshake, rnd[(SHARES-1)*WIDTH-1:0]
//   out_valid/out_ready share-vector handshake, out_shares[SHARES*WIDTH-1:0]
//   enc_count          words delivered on the output, wraps at 2^CNT_W
//   chk_err            (SHARE_ENCODER_CHECK_EN only) sticky share-sum mismatch
//
// Build option
//   SHARE_ENCODER_CHECK_EN: carries a plaintext shadow through both stages and
//   flags any output whose shares do not recombine to it. Verification and
//   fault-detection builds only; the shadow is an unmasked copy.

module share_encoder #(
  parameter int WIDTH  = 4,
  parameter int SHARES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        rnd_valid,
  output logic                        rnd_ready,
  input  logic [(SHARES-1)*WIDTH-1:0] rnd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SHARES*WIDTH-1:0]     out_shares,
  output logic [CNT_W-1:0]            enc_count
`ifdef SHARE_ENCODER_CHECK_EN
  ,
  output logic                        chk_err
`endif
);

  // Stage registers
  logic                        s1_v_q, s1_v_d;
  logic [(SHARES-1)*WIDTH-1:0] s1_r_q, s1_r_d;
  logic [WIDTH-1:0]            s1_m_q, s1_m_d;
  logic                        s2_v_q, s2_v_d;
  logic [SHARES*WIDTH-1:0]     s2_shares_q, s2_shares_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // Transfer events
  logic s2_free, s1_move, s1_free, acc, out_fire;

  assign s2_free  = !s2_v_q || out_ready;
  assign s1_move  = s1_v_q && s2_free;
  assign s1_free  = !s1_v_q || s1_move;
  // Readies are suppressed during reset so nothing is consumed in that cycle.
  assign in_ready  = !rst && rnd_valid && s1_free;
  assign rnd_ready = !rst && in_valid && s1_free;
  assign acc       = in_ready && in_valid;
  assign out_fire  = s2_v_q && out_ready;

  // Progressive XOR chain: each step folds in exactly one more mask, so the
  // intermediate values are always masked by at least one remaining mask.
  logic [WIDTH-1:0] chain [SHARES-1];
  assign chain[0] = s1_m_q;
  generate
    for (genvar gi = 1; gi < SHARES-1; gi++) begin : g_chain
      assign chain[gi] = chain[gi-1] ^ s1_r_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    s1_v_d      = s1_v_q;
    s1_r_d      = s1_r_q;
    s1_m_d      = s1_m_q;
    s2_v_d      = s2_v_q;
    s2_shares_d = s2_shares_q;
    cnt_d       = cnt_q;
    // Stage 1: refill takes priority so bubbles collapse in the move cycle.
    if (acc) begin
      s1_v_d = 1'b1;
      s1_r_d = rnd;
      s1_m_d = in_data ^ rnd[WIDTH-1:0];
    end else if (s1_move) begin
      s1_v_d = 1'b0;
    end
    // Stage 2
    if (s1_move) begin
      s2_v_d      = 1'b1;
      s2_shares_d = {chain[SHARES-2], s1_r_q};
    end else if (out_fire) begin
      s2_v_d = 1'b0;
    end
    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_r_q      <= '0;
      s1_m_q      <= '0;
      s2_v_q      <= 1'b0;
      s2_shares_q <= '0;
      cnt_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_r_q      <= s1_r_d;
      s1_m_q      <= s1_m_d;
      s2_v_q      <= s2_v_d;
      s2_shares_q <= s2_shares_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_shares = s2_shares_q;
  assign enc_count  = cnt_q;

`ifdef SHARE_ENCODER_CHECK_EN
  // Plaintext shadow follows the word through both stages.
  logic [WIDTH-1:0] s1_p_q, s2_p_q;
  logic             chk_err_q;
  logic [WIDTH-1:0] recomb [SHARES];

  assign recomb[0] = s2_shares_q[WIDTH-1:0];
  generate
    for (genvar gi = 1; gi < SHARES; gi++) begin : g_recomb
      assign recomb[gi] = recomb[gi-1] ^ s2_shares_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_p_q    <= '0;
      s2_p_q    <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (acc) begin
        s1_p_q <= in_data;
      end
      if (s1_move) begin
        s2_p_q <= s1_p_q;
      end
      if (s2_v_q && (recomb[SHARES-1] != s2_p_q)) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: doc/share_encoder.md
Name: share_encoder

Overview:
- Converts a plain WIDTH-bit value into a SHARES-share Boolean masking using fresh randomness.
- Produces the share vectors consumed by the masked AND/multiplier gadgets (CMS style), so it sits at the input boundary of the masked datapath.
- Two-stage registered pipeline with valid/ready handshakes on the data input, the randomness input and the share output.
- Randomness is never reused.

Parameters:
- WIDTH, 4, bits per share / plaintext width.
- SHARES, 4, number of output shares (minimum 2).
- CNT_W, 16, width of the encoded-word counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  plaintext word available.
- in_ready  output  1  plaintext word accepted this cycle (when in_valid is also high).
- in_data  input  WIDTH  plaintext word.
- rnd_valid  input  1  fresh randomness available.
- rnd_ready  output  1  randomness consumed this cycle.
- rnd  input  (SHARES-1)*WIDTH  fresh mask bits; slice j is bits [j*WIDTH +: WIDTH].
- out_valid  output  1  share vector valid.
- out_ready  input  1  downstream accepts the share vector.
- out_shares  output  SHARES*WIDTH  share i is bits [i*WIDTH +: WIDTH].
- enc_count  output  CNT_W  number of words delivered on the output.

Behaviour:
- Transfer events:
  - Accept: acc = in_valid & rnd_valid & s1_free.
  - in_ready = rnd_valid & s1_free; rnd_ready = in_valid & s1_free.
  - A plaintext word and a randomness word are only ever consumed together, in the same cycle.
- Stage 1 on acc:
  - s1_r[j] <= rnd slice j, for j = 0..SHARES-2.
  - s1_m <= in_data ^ rnd slice 0.
  - s1_v <= 1.
- Stage 2 on a stage-1 move:
  - share i = s1_r[i] for i < SHARES-1.
  - share SHARES-1 = s1_m ^ s1_r[1] ^ ... ^ s1_r[SHARES-2].
  - The XOR chain is applied progressively, one mask per term, and the result is registered before leaving the block.
  - The plaintext never appears unmasked on any register or output.
- Flow control:
  - s2_free = !s2_v | out_ready.
  - s1_move = s1_v & s2_free; s1_free = !s1_v | s1_move.
  - Full throughput of one word per cycle while out_ready stays high.
  - Latency is 2 cycles from acc to out_valid.
- Backpressure:
  - out_valid and out_shares stay stable while out_valid & !out_ready.
  - Stage 1 holds its word while stage 2 is stalled.
  - With both stages full, in_ready = rnd_ready = 0.
  - Bubbles collapse: stage 1 may refill in the same cycle it moves.
- enc_count:
  - Increments on each out_valid & out_ready.
  - Wraps modulo 2^CNT_W.
- Simultaneous events: accept, stage move and output handshake may all occur in one cycle; each register updates independently per the rules above.
- Reset:
  - s1_v, s2_v, out_valid, enc_count go to 0.
  - in_ready and rnd_ready go to 0 in the reset cycle.
  - Share and data registers are cleared to 0, so stale masks are not retained.
  - Reset mid-operation drops in-flight words without emitting them.
- Missing inputs:
  - rnd_valid = 0 while in_valid = 1: no consumption, in_ready = 0, word held upstream.
  - in_valid = 0 while rnd_valid = 1: rnd_ready = 0, so no randomness is discarded.

Optional Feature:
- Macro: SHARE_ENCODER_CHECK_EN.
- Defined:
  - Stage 1 and stage 2 also carry a plaintext shadow copy.
  - Adds output chk_err (1 bit), set when out_valid and the XOR of all output shares differs from the shadow.
  - chk_err is sticky until rst.
  - For verification and fault-detection builds only.
- Undefined: no shadow registers and no chk_err port; behaviour is otherwise identical.

Test Plan:
- Single encode:
  - Stimulus: WIDTH=4, SHARES=4, in_data=4'hA, rnd=12'h3C5, all valid, out_ready=1.
  - Response: out_valid 2 cycles after accept, out_shares=16'h03C5, enc_count=1.
- Stream:
  - Stimulus: 8 back-to-back words 0..7 with incrementing rnd.
  - Response: one output per cycle after 2-cycle fill; XOR of shares equals input in order; enc_count=8.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while 3 words are offered.
  - Response: exactly 2 words accepted; in_ready=rnd_ready=0 afterwards; out_shares stable; on release, words emerge in order with no loss or duplication.
- Randomness starvation:
  - Stimulus: in_valid=1, rnd_valid=0 for 4 cycles, then rnd_valid=1.
  - Response: no accept and rnd_ready=0 while rnd_valid=0; accept in the first cycle rnd_valid=1; output 2 cycles later.
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle with both stages full.
  - Response: next cycle out_valid=0, enc_count=0, shares 0; the next accepted word encodes correctly.
- Check feature:
  - Stimulus: with SHARE_ENCODER_CHECK_EN defined, force a bit flip on stage-2 share 3.
  - Response: chk_err=1 and remains 1 until rst; unforced runs keep chk_err=0.
